// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: shared FSM states, header layout and counter sizing for spi_regfile
package spi_regfile_pkg;
  typedef enum logic [1:0] {IDLE, HDR, WDATA, RDATA} state_e;
  localparam int R_BIT_POS = 0;
  function automatic int cnt_width(input int aw, input int dw);
    int n;
    n = (1 + aw > dw) ? 1 + aw : dw;
    return $clog2(n);
  endfunction
endpackage

// File: rtl/spi_sync.sv
// spi_sync: 2-flop synchroniser with a third flop for rise/fall detection
module spi_sync (
  input  logic CLK,
  input  logic RST,
  input  logic D,
  output logic Q,
  output logic RISE,
  output logic FALL
);
  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;
  always_comb begin
    meta_d = D;
    sync_d = meta_q;
    prev_d = sync_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) {meta_q, sync_q, prev_q} <= '0;
    else {meta_q, sync_q, prev_q} <= {meta_d, sync_d, prev_d};
  end
  assign Q = sync_q;
  assign RISE = sync_q & ~prev_q;
  assign FALL = ~sync_q & prev_q;
endmodule

// File: rtl/spi_regfile.sv
// spi_regfile: oversampled SPI mode-0 slave with NREG x DATA_W registers, burst read/write
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int NREG = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CS,
  input  logic                     SCLK,
  input  logic                     SDI,
  output logic                     SDO,
  output logic                     SDO_OE,
  output logic [NREG*DATA_W-1:0]   REGS,
  output logic                     WSTB,
  output logic [ADDR_W-1:0]        WADDR
);
  localparam int CW = cnt_width(ADDR_W, DATA_W);
  localparam int IW = NREG > 1 ? $clog2(NREG) : 1;
  localparam logic [CW-1:0] HDR_LAST = CW'(ADDR_W);
  localparam logic [CW-1:0] WORD_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] R_POS = CW'(R_BIT_POS);
  logic cs_s, cs_rise, cs_fall, sclk_s, sclk_rise, sclk_fall;
  logic sdi_meta_q, sdi_q;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rd_q, rd_d, skip_q, skip_d, oe_q, oe_d, wstb_q, wstb_d, armed_q, armed_d;
  logic [1:0] settle_q, settle_d;
  logic [ADDR_W-1:0] addr_q, addr_d, waddr_q, waddr_d, addr_inc;
  logic [DATA_W-1:0] wsh_q, wsh_d, sr_q, sr_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  spi_sync u_cs (.CLK(CLK), .RST(RST), .D(CS), .Q(cs_s), .RISE(cs_rise), .FALL(cs_fall));
  spi_sync u_sclk (.CLK(CLK), .RST(RST), .D(SCLK), .Q(sclk_s), .RISE(sclk_rise), .FALL(sclk_fall));
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return int'(a) < NREG;
  endfunction
  function automatic logic [DATA_W-1:0] rword(input logic [ADDR_W-1:0] a);
    return in_range(a) ? regs_q[a[IW-1:0]] : '0;
  endfunction
  assign addr_inc = (int'(addr_q) + 1 >= NREG) ? '0 : addr_q + ADDR_W'(1);
  // Arm only once the synchronisers have settled on an idle bus, so a CS held high through reset is ignored
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rd_d = rd_q;
    skip_d = skip_q;
    oe_d = oe_q;
    addr_d = addr_q;
    waddr_d = waddr_q;
    wsh_d = wsh_q;
    sr_d = sr_q;
    regs_d = regs_q;
    wstb_d = 1'b0;
    settle_d = settle_q + 2'(settle_q != 2'd3);
    armed_d = armed_q | (settle_q == 2'd3 && !cs_s && !sclk_s);
    if (cs_fall) begin
      state_d = IDLE;
      cnt_d = '0;
      oe_d = 1'b0;
      sr_d = '0;
    end else begin
      case (state_q)
        IDLE: if (cs_rise && armed_q) begin
          state_d = HDR;
          cnt_d = '0;
          rd_d = 1'b0;
          addr_d = '0;
        end
        HDR: if (sclk_rise) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == R_POS) rd_d = sdi_q;
          else addr_d = ADDR_W'({addr_q, sdi_q});
          if (cnt_q == HDR_LAST) begin
            state_d = rd_q ? RDATA : WDATA;
            cnt_d = '0;
            if (rd_q) begin
              sr_d = rword(addr_d);
              skip_d = 1'b1;
              oe_d = 1'b1;
            end
          end
        end
        WDATA: if (sclk_rise) begin
          cnt_d = cnt_q + CW'(1);
          wsh_d = DATA_W'({wsh_q, sdi_q});
          if (cnt_q == WORD_LAST) begin
            cnt_d = '0;
            addr_d = addr_inc;
            if (in_range(addr_q)) begin
              regs_d[addr_q[IW-1:0]] = wsh_d;
              wstb_d = 1'b1;
              waddr_d = addr_q;
            end
          end
        end
        RDATA: if (sclk_rise) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == WORD_LAST) begin
            cnt_d = '0;
            addr_d = addr_inc;
            sr_d = rword(addr_inc);
            skip_d = 1'b1;
          end
        end else if (sclk_fall) begin
          skip_d = 1'b0;
          sr_d = skip_q ? sr_q : sr_q << 1;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rd_q <= 1'b0;
      skip_q <= 1'b0;
      oe_q <= 1'b0;
      wstb_q <= 1'b0;
      armed_q <= 1'b0;
      settle_q <= '0;
      addr_q <= '0;
      waddr_q <= '0;
      wsh_q <= '0;
      sr_q <= '0;
      regs_q <= '{default: '0};
      sdi_meta_q <= 1'b0;
      sdi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rd_q <= rd_d;
      skip_q <= skip_d;
      oe_q <= oe_d;
      wstb_q <= wstb_d;
      armed_q <= armed_d;
      settle_q <= settle_d;
      addr_q <= addr_d;
      waddr_q <= waddr_d;
      wsh_q <= wsh_d;
      sr_q <= sr_d;
      regs_q <= regs_d;
      sdi_meta_q <= SDI;
      sdi_q <= sdi_meta_q;
    end
  end
  for (genvar i = 0; i < NREG; i++) assign REGS[i*DATA_W +: DATA_W] = regs_q[i];
  assign SDO = sr_q[DATA_W-1];
  assign SDO_OE = oe_q;
  assign WSTB = wstb_q;
  assign WADDR = waddr_q;
endmodule

// File: tb/tb_spi_regfile.sv
// tb_spi_regfile: directed SPI frames with write/read scoreboards against a register model
module tb_spi_regfile;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NR = 4;
  logic clk = 1'b0;
  logic rst, cs, sclk, sdi, sdo, sdo_oe, wstb;
  logic [NR*DW-1:0] regs;
  logic [AW-1:0] waddr;
  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  wr_t wq[$];
  wr_t we;
  logic [7:0] rq[$];
  logic [7:0] mem [NR];
  logic [7:0] cur;
  int n_cmp = 0;
  int n_bad = 0;
  spi_regfile #(.ADDR_W(AW), .DATA_W(DW), .NREG(NR)) dut (
    .CLK(clk), .RST(rst), .CS(cs), .SCLK(sclk), .SDI(sdi), .SDO(sdo), .SDO_OE(sdo_oe),
    .REGS(regs), .WSTB(wstb), .WADDR(waddr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst === 1'b0 && wstb === 1'b1) begin
      if (wq.size() == 0) chk("wstb_unexpected", 64'd1, 64'd0);
      else begin
        we = wq.pop_front();
        chk("waddr", 64'(waddr), 64'(we.a));
        chk("wdata", 64'(regs[we.a*8 +: 8]), 64'(we.d));
      end
    end
  end
  function automatic logic [7:0] nxt(input logic [7:0] a);
    return (int'(a) + 1 >= NR) ? 8'd0 : a + 8'd1;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic cs_up;
    cs = 1'b1;
    tick(8);
  endtask
  task automatic cs_down;
    tick(8);
    cs = 1'b0;
    tick(8);
    chk("oe_after_cs", 64'(sdo_oe), 64'd0);
    chk("pending_writes", 64'(wq.size()), 64'd0);
  endtask
  task automatic bit_x(input logic b, output logic so, output logic oe);
    sdi = b;
    tick(8);
    so = sdo;
    oe = sdo_oe;
    sclk = 1'b1;
    tick(8);
    sclk = 1'b0;
  endtask
  task automatic hdr(input logic r, input logic [7:0] a);
    logic so, oe;
    logic [8:0] h;
    h = {r, a};
    cur = a;
    for (int i = 8; i >= 0; i--) begin
      bit_x(h[i], so, oe);
      chk("oe_hdr", 64'(oe), 64'd0);
    end
  endtask
  task automatic wr(input logic [7:0] d, input int nbits, input bit exp);
    logic so, oe;
    if (exp && nbits == 8 && int'(cur) < NR) begin
      wq.push_back(wr_t'{a: cur, d: d});
      mem[cur[1:0]] = d;
    end
    for (int i = 7; i > 7 - nbits; i--) begin
      bit_x(d[i], so, oe);
      chk("oe_wdata", 64'(oe), 64'd0);
    end
    if (nbits == 8) cur = nxt(cur);
  endtask
  task automatic rd_word;
    logic so, oe;
    logic [7:0] got;
    rq.push_back(int'(cur) < NR ? mem[cur[1:0]] : 8'h00);
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b0, so, oe);
      got[i] = so;
      chk("oe_rdata", 64'(oe), 64'd1);
    end
    chk("rdata", 64'(got), 64'(rq.pop_front()));
    cur = nxt(cur);
  endtask
  task automatic chk_regs;
    chk("regs", 64'(regs), 64'({mem[3], mem[2], mem[1], mem[0]}));
  endtask
  initial begin
    rst = 1'b1;
    cs = 1'b0;
    sclk = 1'b0;
    sdi = 1'b0;
    cur = 8'd0;
    for (int i = 0; i < NR; i++) mem[i] = 8'h00;
    tick(4);
    rst = 1'b0;
    tick(6);
    chk("rst_regs", 64'(regs), 64'd0);
    chk("rst_sdo", 64'(sdo), 64'd0);
    chk("rst_oe", 64'(sdo_oe), 64'd0);
    chk("rst_wstb", 64'(wstb), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    cs_up; hdr(1'b0, 8'h01); wr(8'hA5, 8, 1'b1); cs_down; chk_regs;
    cs_up; hdr(1'b0, 8'h03); wr(8'h11, 8, 1'b1); wr(8'h22, 8, 1'b1); cs_down; chk_regs;
    cs_up; hdr(1'b1, 8'h03); rd_word; rd_word; cs_down; chk_regs;
    cs_up; hdr(1'b0, 8'h02); wr(8'h77, 5, 1'b0); cs_down; chk_regs;
    cs_up; hdr(1'b0, 8'h02); wr(8'h3C, 8, 1'b1); cs_down; chk_regs;
    cs_up; hdr(1'b0, 8'h07); wr(8'hFF, 8, 1'b1); cs_down; chk_regs;
    cs_up; hdr(1'b1, 8'h07); rd_word; cs_down;
    cs_up; hdr(1'b0, 8'h01); wr(8'h5A, 3, 1'b0);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) mem[i] = 8'h00;
    wr(8'hC3, 8, 1'b0);
    chk_regs;
    chk("oe_after_rst", 64'(sdo_oe), 64'd0);
    cs_down; chk_regs;
    cs_up; hdr(1'b0, 8'h00); wr(8'h96, 8, 1'b1); cs_down; chk_regs;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
